// File: rtl/store_beat_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : store_beat_unit_if
// Description : Store request, bus write beat and completion signals of the
//               store beat unit. The unit is the master.
// Revision    : 1.0 - initial release
// ============================================================================
interface store_beat_unit_if #(
    parameter int DATA_W = 64
);
    localparam int c_nb = DATA_W / 8;

    logic                req_valid;
    logic                req_ready;
    logic [63:0]         req_addr;
    logic [63:0]         req_data;
    logic [1:0]          req_size;
    logic                bus_valid;
    logic [63:0]         bus_addr;
    logic [DATA_W-1:0]   bus_data;
    logic [c_nb-1:0]     bus_strobe;
    logic                bus_ok;
    logic                done;
    logic                err;

    modport master (
        input  req_valid, req_addr, req_data, req_size, bus_ok,
        output req_ready, bus_valid, bus_addr, bus_data, bus_strobe, done, err
    );

    modport slave (
        output req_valid, req_addr, req_data, req_size, bus_ok,
        input  req_ready, bus_valid, bus_addr, bus_data, bus_strobe, done, err
    );
endinterface
`default_nettype wire

// File: rtl/store_beat_unit.sv
`default_nettype none
// ============================================================================
// Module      : store_beat_unit
// Description : Turns one store request into one or two byte-strobed write
//               beats on a DATA_W-wide bus and pulses done/err on completion.
// Revision    : 1.0 - initial release
// ============================================================================
module store_beat_unit #(
    parameter int DATA_W         = 64,
    parameter bit ALLOW_MISALIGN = 1'b1
) (
    input  wire logic          clk,
    input  wire logic          resetn,
    store_beat_unit_if.master  sif
);
    localparam int c_nb    = DATA_W / 8;
    localparam int c_off_w = $clog2(c_nb);
    localparam int c_sum_w = c_off_w + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BEAT0 = 2'd1,
        S_BEAT1 = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_bus_valid;
    logic [63:0]         r_bus_addr;
    logic [DATA_W-1:0]   r_bus_data;
    logic [c_nb-1:0]     r_bus_strobe;
    logic [DATA_W-1:0]   r_data_hi;
    logic [c_nb-1:0]     r_strobe_hi;
    logic                r_cross;
    logic                r_done;
    logic                r_err;

    logic [c_off_w-1:0]  w_off;
    logic [3:0]          w_nbytes;
    logic [2:0]          w_amask;
    logic [7:0]          w_lanes8;
    logic [63:0]         w_dmask;
    logic                w_misalign;
    logic                w_cross;
    logic [2*c_nb-1:0]   w_mask2;
    logic [2*DATA_W-1:0] w_data2;
    logic [63:0]         w_base;

    always_comb begin
        w_amask  = 3'b000;
        w_lanes8 = 8'h01;
        case (req_size_q())
            2'd0: begin w_amask = 3'b000; w_lanes8 = 8'h01; end
            2'd1: begin w_amask = 3'b001; w_lanes8 = 8'h03; end
            2'd2: begin w_amask = 3'b011; w_lanes8 = 8'h0F; end
            default: begin w_amask = 3'b111; w_lanes8 = 8'hFF; end
        endcase
    end

    function automatic logic [1:0] req_size_q();
        return sif.req_size;
    endfunction

    for (genvar i = 0; i < 8; i++) begin : g_bytemask
        assign w_dmask[8*i +: 8] = {8{w_lanes8[i]}};
    end

    assign w_off      = sif.req_addr[c_off_w-1:0];
    assign w_nbytes   = 4'd1 << sif.req_size;
    assign w_misalign = |(sif.req_addr[2:0] & w_amask);
    assign w_cross    = ({1'b0, w_off} + c_sum_w'(w_nbytes)) > c_sum_w'(c_nb);
    assign w_base     = {sif.req_addr[63:c_off_w], {c_off_w{1'b0}}};
    // Placing over a double-width window lets the upper half become beat 1.
    assign w_mask2    = {{(2*c_nb-8){1'b0}}, w_lanes8} << w_off;
    assign w_data2    = {{(2*DATA_W-64){1'b0}}, sif.req_data & w_dmask} << {w_off, 3'b000};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_bus_valid  <= 1'b0;
            r_bus_addr   <= '0;
            r_bus_data   <= '0;
            r_bus_strobe <= '0;
            r_data_hi    <= '0;
            r_strobe_hi  <= '0;
            r_cross      <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (sif.req_valid) begin
                        if (w_misalign && !ALLOW_MISALIGN) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else begin
                            r_state      <= S_BEAT0;
                            r_bus_valid  <= 1'b1;
                            r_bus_addr   <= w_base;
                            r_bus_data   <= w_data2[DATA_W-1:0];
                            r_bus_strobe <= w_mask2[c_nb-1:0];
                            r_data_hi    <= w_data2[2*DATA_W-1:DATA_W];
                            r_strobe_hi  <= w_mask2[2*c_nb-1:c_nb];
                            r_cross      <= w_cross;
                        end
                    end
                end
                S_BEAT0: begin
                    if (sif.bus_ok) begin
                        if (r_cross) begin
                            r_state      <= S_BEAT1;
                            r_bus_addr   <= r_bus_addr + 64'(c_nb);
                            r_bus_data   <= r_data_hi;
                            r_bus_strobe <= r_strobe_hi;
                        end else begin
                            r_state     <= S_DONE;
                            r_bus_valid <= 1'b0;
                            r_done      <= 1'b1;
                        end
                    end
                end
                S_BEAT1: begin
                    if (sif.bus_ok) begin
                        r_state     <= S_DONE;
                        r_bus_valid <= 1'b0;
                        r_done      <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                end
            endcase
        end
    end

    assign sif.req_ready  = (r_state == S_IDLE);
    assign sif.bus_valid  = r_bus_valid;
    assign sif.bus_addr   = r_bus_addr;
    assign sif.bus_data   = r_bus_data;
    assign sif.bus_strobe = r_bus_strobe;
    assign sif.done       = r_done;
    assign sif.err        = r_err;
endmodule
`default_nettype wire

// File: tb/tb_store_beat_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_beat_unit
// Description : Scoreboard bench for store_beat_unit across three
//               configurations (64/allow, 64/reject, 128/allow).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_beat_unit;
    typedef struct {
        logic [63:0]  addr;
        logic [127:0] data;
        logic [15:0]  strobe;
    } beat_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0;
    logic        bus_ok    = 1'b0;
    logic [63:0] req_addr  = '0;
    logic [63:0] req_data  = '0;
    logic [1:0]  req_size  = '0;
    int          sel       = 0;

    logic         o_req_ready, o_bus_valid, o_done, o_err;
    logic [63:0]  o_bus_addr;
    logic [127:0] o_bus_data;
    logic [15:0]  o_bus_strobe;

    int n_checks = 0;
    int n_errors = 0;
    beat_t beat_q[$];
    bit    err_q[$];

    store_beat_unit_if #(.DATA_W(64))  if_a ();
    store_beat_unit_if #(.DATA_W(64))  if_n ();
    store_beat_unit_if #(.DATA_W(128)) if_w ();

    store_beat_unit #(.DATA_W(64),  .ALLOW_MISALIGN(1'b1)) dut_a (.clk(clk), .resetn(resetn), .sif(if_a));
    store_beat_unit #(.DATA_W(64),  .ALLOW_MISALIGN(1'b0)) dut_n (.clk(clk), .resetn(resetn), .sif(if_n));
    store_beat_unit #(.DATA_W(128), .ALLOW_MISALIGN(1'b1)) dut_w (.clk(clk), .resetn(resetn), .sif(if_w));

    assign if_a.req_valid = req_valid && (sel == 0);
    assign if_n.req_valid = req_valid && (sel == 1);
    assign if_w.req_valid = req_valid && (sel == 2);
    assign if_a.bus_ok    = bus_ok && (sel == 0);
    assign if_n.bus_ok    = bus_ok && (sel == 1);
    assign if_w.bus_ok    = bus_ok && (sel == 2);
    assign if_a.req_addr = req_addr;  assign if_a.req_data = req_data;  assign if_a.req_size = req_size;
    assign if_n.req_addr = req_addr;  assign if_n.req_data = req_data;  assign if_n.req_size = req_size;
    assign if_w.req_addr = req_addr;  assign if_w.req_data = req_data;  assign if_w.req_size = req_size;

    always_comb begin
        o_req_ready  = if_a.req_ready;
        o_bus_valid  = if_a.bus_valid;
        o_done       = if_a.done;
        o_err        = if_a.err;
        o_bus_addr   = if_a.bus_addr;
        o_bus_data   = {64'b0, if_a.bus_data};
        o_bus_strobe = {8'b0, if_a.bus_strobe};
        if (sel == 1) begin
            o_req_ready  = if_n.req_ready;
            o_bus_valid  = if_n.bus_valid;
            o_done       = if_n.done;
            o_err        = if_n.err;
            o_bus_addr   = if_n.bus_addr;
            o_bus_data   = {64'b0, if_n.bus_data};
            o_bus_strobe = {8'b0, if_n.bus_strobe};
        end else if (sel == 2) begin
            o_req_ready  = if_w.req_ready;
            o_bus_valid  = if_w.bus_valid;
            o_done       = if_w.done;
            o_err        = if_w.err;
            o_bus_addr   = if_w.bus_addr;
            o_bus_data   = if_w.bus_data;
            o_bus_strobe = if_w.bus_strobe;
        end
    end

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: walks the store byte by byte into beat/lane positions.
    task automatic push_expected(input int nb, input bit allow, input logic [63:0] addr,
                                 input logic [63:0] data, input logic [1:0] size,
                                 output int nbeats, output bit exp_err);
        int    n, off, p;
        beat_t b[2];
        n   = 1 << size;
        off = int'(addr % 64'(nb));
        exp_err = !allow && ((addr % 64'(n)) != 0);
        nbeats  = 0;
        if (!exp_err) begin
            nbeats = (off + n > nb) ? 2 : 1;
            for (int k = 0; k < 2; k++) begin
                b[k].addr   = addr - 64'(off) + 64'(k * nb);
                b[k].data   = '0;
                b[k].strobe = '0;
            end
            for (int i = 0; i < n; i++) begin
                p = off + i;
                b[p / nb].strobe[p % nb] = 1'b1;
                b[p / nb].data[8*(p % nb) +: 8] = data[8*i +: 8];
            end
            for (int k = 0; k < nbeats; k++) beat_q.push_back(b[k]);
        end
        err_q.push_back(exp_err);
    endtask

    task automatic do_store(input int s, input logic [63:0] a, input logic [63:0] d,
                            input logic [1:0] sz, input int stalls, input bit abort_b1);
        int    nbeats, t, st, served, lat;
        bit    exp_err, fin;
        beat_t e;
        @(negedge clk);
        sel = s;
        #1;
        check_val("ready_idle", o_req_ready, 1);
        push_expected((s == 2) ? 16 : 8, s != 1, a, d, sz, nbeats, exp_err);
        lat = exp_err ? 1 : 1 + nbeats + stalls;
        req_valid = 1'b1; req_addr = a; req_data = d; req_size = sz;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_data  = ~d;
        t = 1; st = stalls; served = 0; fin = 0;
        while (!fin && t < 60) begin
            if (o_done) begin
                check_val("err", o_err, err_q.size() > 0 ? err_q.pop_front() : 1'bx);
                check_val("beats_left", beat_q.size(), 0);
                check_val("latency", t, lat);
                bus_ok = 1'b0;
                fin = 1;
            end else begin
                check_val("err_idle", o_err, 0);
                if (o_bus_valid) begin
                    if (t == 1) check_val("ready_busy", o_req_ready, 0);
                    if (beat_q.size() == 0) begin
                        check_val("unexpected_beat", o_bus_valid, 0);
                        fin = 1;
                    end else begin
                        e = beat_q[0];
                        check_val("bus_addr", o_bus_addr, e.addr);
                        check_val("bus_data", o_bus_data, e.data);
                        check_val("bus_strobe", o_bus_strobe, e.strobe);
                        if (abort_b1 && served == 1) begin
                            bus_ok = 1'b0;
                            resetn = 1'b0;
                            #1;
                            check_val("rst_bus_valid", o_bus_valid, 0);
                            check_val("rst_done", o_done, 0);
                            beat_q.delete();
                            err_q.delete();
                            @(negedge clk);
                            check_val("rst_done_hold", o_done, 0);
                            resetn = 1'b1;
                            #1;
                            check_val("rst_ready", o_req_ready, 1);
                            fin = 1;
                        end else if (st > 0) begin
                            bus_ok = 1'b0;
                            st--;
                        end else begin
                            bus_ok = 1'b1;
                            void'(beat_q.pop_front());
                            served++;
                        end
                    end
                end else begin
                    bus_ok = 1'b0;
                end
            end
            if (!fin) begin
                @(posedge clk);
                @(negedge clk);
                t++;
            end
        end
        bus_ok = 1'b0;
        check_val("completed", fin, 1);
        if (!fin) begin
            beat_q.delete();
            err_q.delete();
        end
    endtask

    initial begin
        #12;
        check_val("rst_bus_valid", o_bus_valid, 0);
        check_val("rst_done", o_done, 0);
        check_val("rst_err", o_err, 0);
        check_val("rst_bus_addr", o_bus_addr, 0);
        check_val("rst_bus_data", o_bus_data, 0);
        check_val("rst_bus_strobe", o_bus_strobe, 0);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check_val("rst_ready", o_req_ready, 1);

        do_store(0, 64'h2007, 64'h0000_0000_0000_00AB, 2'd0, 3, 1'b0);
        do_store(0, 64'h1005, 64'h1122_3344_5566_7788, 2'd3, 0, 1'b0);
        do_store(0, 64'h1003, 64'hFFFF_FFFF_FFFF_BEEF, 2'd1, 1, 1'b0);
        do_store(1, 64'h1003, 64'h0000_0000_0000_BEEF, 2'd1, 0, 1'b0);
        do_store(1, 64'h2008, 64'h0000_0000_1234_5678, 2'd2, 2, 1'b0);
        do_store(2, 64'h100C, 64'h5555_5555_DEAD_BEEF, 2'd2, 0, 1'b0);
        do_store(2, 64'h100E, 64'h0102_0304_0506_0708, 2'd3, 2, 1'b0);
        do_store(0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_CAFE_F00D, 2'd2, 1, 1'b0);
        do_store(0, 64'h1005, 64'h1122_3344_5566_7788, 2'd3, 0, 1'b1);
        do_store(0, 64'h3004, 64'hA1B2_C3D4_E5F6_0718, 2'd3, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            do_store(int'($urandom_range(0, 2)), {$urandom, $urandom}, {$urandom, $urandom},
                     2'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/store_beat_unit.md
# store_beat_unit

Parametrised store unit between the memory stage and the data-bus port. It accepts one store request at a time, converts it into one or two bus write beats on a `DATA_W`-wide bus with byte strobes, and reports completion. Unlike the single-cycle 64-bit byte-lane formatter, it supports a wider bus, optional misaligned stores, and two-beat splits across a bus-word boundary. It also holds the bus request until the bus acknowledges it.

## Interface
Parameters:
- `DATA_W`, 64, bus data width in bits; legal values 64 or 128. `NB = DATA_W/8` strobe bits.
- `ALLOW_MISALIGN`, 1, 1: misaligned stores are executed, split if needed; 0: misaligned stores complete with error and no bus traffic.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock
- `resetn`  in  1  asynchronous active-low reset
- `req_valid`  in  1  store request present
- `req_ready`  out  1  unit can accept a request
- `req_addr`  in  64  byte address
- `req_data`  in  64  store data, right-aligned (`word_t`)
- `req_size`  in  2  `msize_t`: MSIZE1=0, MSIZE2=1, MSIZE4=2, MSIZE8=3
- `bus_valid`  out  1  write beat valid
- `bus_addr`  out  64  beat address, aligned to `NB`
- `bus_data`  out  DATA_W  beat data, byte-lane placed
- `bus_strobe`  out  NB  byte write enables
- `bus_ok`  in  1  beat accepted and written; meaningful only while `bus_valid`=1
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  valid with `done`; 1 = misaligned store rejected

## Operation
- States: IDLE, BEAT0, BEAT1, DONE.
- `req_ready` = 1 only in IDLE. A request is accepted when `req_valid && req_ready`. On acceptance the unit registers the address, data, size and derived lane fields.
- n = 1 << `req_size`. off = `req_addr` mod NB. The request is misaligned when `req_addr` mod n ≠ 0. It crosses when off + n > NB.
- The lane mask is computed over 2·NB bits: ((1<<n)−1) << off. The data is computed over 2·DATA_W bits: (`req_data` masked to 8n bits) << 8·off.
- Beat 0 uses the low half of the mask and data, with address `req_addr` & ~(NB−1).
- Beat 1 uses the high half, with the beat-0 address + NB. Address arithmetic wraps modulo 2^64.
- Non-enabled bytes of `bus_data` are 0.
- Transitions:
  - IDLE → DONE with err=1 when accepted with misaligned=1 and `ALLOW_MISALIGN`=0.
  - IDLE → BEAT0 otherwise.
  - BEAT0 → BEAT1 on `bus_ok` if crossing; BEAT0 → DONE on `bus_ok` if not crossing.
  - BEAT1 → DONE on `bus_ok`.
  - DONE → IDLE unconditionally.
- In BEAT0 and BEAT1, `bus_valid`=1. `bus_addr`, `bus_data` and `bus_strobe` stay stable until `bus_ok`. Only one beat is outstanding at a time.
- Crossing is impossible when the store is aligned, because n ≤ 8 ≤ NB.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE.
  - `bus_valid`, `done`, `err` = 0.
  - `bus_addr`, `bus_data`, `bus_strobe` = 0.
  - `req_ready` = 1 once `resetn` is high.
- Reset mid-beat drops `bus_valid` asynchronously. The store is abandoned and no `done` is raised.
- Outputs are registered or decoded from state. No combinational path exists from `req_*` or `bus_ok` to any output.
- Accept at cycle 0 → `bus_valid` at cycle 1.
- `bus_ok` at cycle k → next beat's `bus_valid` at k+1, with no bubble. Otherwise `done` is raised at k+1.
- Minimum latency:
  - Single beat: `done` at cycle 2, `req_ready` at cycle 3.
  - Two beats: `done` at cycle 3.
  - Error: `done`/`err` at cycle 1.
- Back-to-back throughput: one single-beat store every 3 cycles.
- `bus_ok` while `bus_valid`=0 is ignored. `req_valid` outside IDLE is ignored; the requester holds the request.
- `err` = 0 whenever `done` = 0.

## Test plan
- Byte store, `DATA_W`=64, addr 0x2007, data 0xAB → single beat at 0x2000, strobe 0x80, data 0xAB00000000000000, held across 3 stall cycles until `bus_ok`; `done`=1, `err`=0 the next cycle.
- Crossing store, `DATA_W`=64, `ALLOW_MISALIGN`=1, MSIZE8, addr 0x1005, data 0x1122334455667788 → two beats:
  - Beat 0: 0x1000, strobe 0xE0, data 0x6677880000000000.
  - Beat 1: 0x1008, strobe 0x1F, data 0x0000001122334455.
  - `done` the cycle after the second `bus_ok`.
- Misaligned non-crossing store, MSIZE2, addr 0x1003, data 0xBEEF:
  - `ALLOW_MISALIGN`=1 → one beat, strobe 0x18, data 0x000000BEEF000000.
  - `ALLOW_MISALIGN`=0 → no `bus_valid`; `done`=`err`=1 at cycle 1.
- `DATA_W`=128, MSIZE4, addr 0x100C, data 0xDEADBEEF → beat at 0x1000, strobe 0xF000, `bus_data`[127:96]=0xDEADBEEF, all other bits 0.
- Wrap: `DATA_W`=64, MSIZE4, addr 0xFFFFFFFFFFFFFFFE → beat 0 at 0xFFFFFFFFFFFFFFF8 with strobe 0xC0; beat 1 at 0x0 with strobe 0x03.
- Reset asserted during beat 1 of a crossing store → `bus_valid`=0 immediately, no `done`, `req_ready`=1 after release; the next store proceeds normally.
